// File: rtl/intr_stat_ctrl.sv
// Interrupt status collector: per-source edge/level detection, sticky W1C status and
// overflow flags, registered aggregate. Define INTR_SYNC_EN to add 2-flop input synchronizers.
module intr_stat_ctrl #(
   parameter int unsigned N_SRC = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_SRC-1:0] i_src,
   input  logic [N_SRC-1:0] i_src_edge,
   input  logic [N_SRC-1:0] i_en,
   input  logic             i_clr_valid,
   input  logic [N_SRC-1:0] i_clr_mask,
   input  logic             i_set_valid,
   input  logic [N_SRC-1:0] i_set_mask,
   output logic [N_SRC-1:0] o_raw_stat,
   output logic [N_SRC-1:0] o_ovf,
   output logic             o_intr_stat
);

   logic [N_SRC-1:0] src_s;
   logic [N_SRC-1:0] src_d_r;
   logic [N_SRC-1:0] stat_r;
   logic [N_SRC-1:0] ovf_r;
   logic [N_SRC-1:0] evt;
   logic [N_SRC-1:0] set_vec;
   logic [N_SRC-1:0] clr_vec;
   logic [N_SRC-1:0] stat_nxt;
   logic [N_SRC-1:0] ovf_nxt;

`ifdef INTR_SYNC_EN
   logic [N_SRC-1:0] sync1_r;
   logic [N_SRC-1:0] sync2_r;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
      end else begin
         sync1_r <= i_src;
         sync2_r <= sync1_r;
      end
   end

   assign src_s = sync2_r;
`else
   assign src_s = i_src;
`endif

   // Set has priority over clear so an event arriving with a W1C is never lost.
   always_comb begin
      evt      = (src_s & ~src_d_r & i_src_edge) | (src_s & ~i_src_edge);
      set_vec  = evt | ({N_SRC{i_set_valid}} & i_set_mask);
      clr_vec  = {N_SRC{i_clr_valid}} & i_clr_mask;
      stat_nxt = set_vec | (stat_r & ~clr_vec);
      ovf_nxt  = (evt & stat_r & ~clr_vec & i_src_edge) | (ovf_r & ~clr_vec);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         src_d_r     <= '0;
         stat_r      <= '0;
         ovf_r       <= '0;
         o_intr_stat <= 1'b0;
      end else begin
         src_d_r     <= src_s;
         stat_r      <= stat_nxt;
         ovf_r       <= ovf_nxt;
         o_intr_stat <= |(stat_r & i_en);
      end
   end

   assign o_raw_stat = stat_r;
   assign o_ovf      = ovf_r;

endmodule

// File: tb/tb_intr_stat_ctrl.sv
// Scoreboard bench for intr_stat_ctrl: directed scenarios followed by random traffic,
// each cycle's expected outputs computed from per-source rules and queued for the monitor.
module tb_intr_stat_ctrl;

   localparam int unsigned N = 8;
`ifdef INTR_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   typedef struct {
      logic [N-1:0] raw;
      logic [N-1:0] ovf;
      logic         intr;
   } exp_t;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic [N-1:0] i_src = '0;
   logic [N-1:0] i_src_edge = '0;
   logic [N-1:0] i_en = '0;
   logic         i_clr_valid = 1'b0;
   logic [N-1:0] i_clr_mask = '0;
   logic         i_set_valid = 1'b0;
   logic [N-1:0] i_set_mask = '0;
   logic [N-1:0] o_raw_stat;
   logic [N-1:0] o_ovf;
   logic         o_intr_stat;

   intr_stat_ctrl #(.N_SRC(N)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src(i_src), .i_src_edge(i_src_edge),
      .i_en(i_en), .i_clr_valid(i_clr_valid), .i_clr_mask(i_clr_mask),
      .i_set_valid(i_set_valid), .i_set_mask(i_set_mask),
      .o_raw_stat(o_raw_stat), .o_ovf(o_ovf), .o_intr_stat(o_intr_stat)
   );

   always #5 i_clk = ~i_clk;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference state, one entry per source.
   bit m_stat[N];
   bit m_ovf[N];
   bit m_prev[N];
   bit m_sy1[N];
   bit m_sy2[N];
   bit m_intr;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_stat[i] = 0; m_ovf[i] = 0; m_prev[i] = 0; m_sy1[i] = 0; m_sy2[i] = 0;
      end
      m_intr = 0;
   endfunction

   function automatic exp_t snapshot();
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.raw[i] = m_stat[i];
         e.ovf[i] = m_ovf[i];
      end
      e.intr = m_intr;
      return e;
   endfunction

   // Advance the model across one rising edge using the inputs currently driven.
   function automatic void model_step();
      bit any_en = 0;
      for (int i = 0; i < N; i++) begin
         bit s, evt, set_b, clr_b;
         s = SYNC ? m_sy2[i] : i_src[i];
         if (i_src_edge[i]) evt = s && !m_prev[i];
         else               evt = s;
         set_b = evt || (i_set_valid && i_set_mask[i]);
         clr_b = i_clr_valid && i_clr_mask[i];
         if (m_stat[i] && i_en[i]) any_en = 1;
         if (evt && m_stat[i] && !clr_b && i_src_edge[i]) m_ovf[i] = 1;
         else if (clr_b)                                 m_ovf[i] = 0;
         if (set_b)      m_stat[i] = 1;
         else if (clr_b) m_stat[i] = 0;
         m_prev[i] = s;
         m_sy2[i]  = m_sy1[i];
         m_sy1[i]  = i_src[i];
      end
      m_intr = any_en;
   endfunction

   task automatic drive(input logic [N-1:0] src, input logic [N-1:0] edg, input logic [N-1:0] en,
                        input logic cv, input logic [N-1:0] cm,
                        input logic sv, input logic [N-1:0] sm);
      @(negedge i_clk);
      i_rst_n     = 1'b1;
      i_src       = src;
      i_src_edge  = edg;
      i_en        = en;
      i_clr_valid = cv;
      i_clr_mask  = cm;
      i_set_valid = sv;
      i_set_mask  = sm;
      model_step();
      exp_q.push_back(snapshot());
   endtask

   task automatic async_reset();
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_raw",  32'(o_raw_stat), 32'h0);
      chk("rst_ovf",  32'(o_ovf), 32'h0);
      chk("rst_intr", 32'(o_intr_stat), 32'h0);
      model_reset();
      exp_q.push_back(snapshot());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("raw_stat",  32'(o_raw_stat), 32'(e.raw));
            chk("ovf",       32'(o_ovf), 32'(e.ovf));
            chk("intr_stat", 32'(o_intr_stat), 32'(e.intr));
         end
      end
   end

   initial begin : driver
      logic [N-1:0] edg, en, src;
      model_reset();
      #1;
      chk("init_raw",  32'(o_raw_stat), 32'h0);
      chk("init_ovf",  32'(o_ovf), 32'h0);
      chk("init_intr", 32'(o_intr_stat), 32'h0);
      repeat (2) @(negedge i_clk);

      edg = 8'h07;
      en  = 8'h01;
      // Edge pulse on src0, later W1C
      repeat (3) drive('0, edg, en, 0, '0, 0, '0);
      drive(8'h01, edg, en, 0, '0, 0, '0);
      repeat (6) drive('0, edg, en, 0, '0, 0, '0);
      drive('0, edg, en, 1, 8'h01, 0, '0);
      repeat (4) drive('0, edg, en, 0, '0, 0, '0);
      // Overflow on src1: two edges, then clear
      drive(8'h02, edg, en, 0, '0, 0, '0);
      repeat (4) drive('0, edg, en, 0, '0, 0, '0);
      drive(8'h02, edg, en, 0, '0, 0, '0);
      repeat (3) drive('0, edg, en, 0, '0, 0, '0);
      drive('0, edg, en, 1, 8'h02, 0, '0);
      drive('0, edg, en, 0, '0, 0, '0);
      // Set-wins on src2
      drive(8'h04, edg, en, 1, 8'h04, 0, '0);
      repeat (3) drive('0, edg, en, 0, '0, 0, '0);
      // Level hold on src3
      for (int c = 0; c < 10; c++) drive(8'h08, edg, en, (c == 5), 8'h08, 0, '0);
      drive('0, edg, en, 0, '0, 0, '0);
      repeat (3) drive('0, edg, en, 1, 8'h08, 0, '0);
      // Enable gating on src4, then software set of bit 7
      drive(8'h10, edg, 8'h00, 0, '0, 0, '0);
      repeat (3) drive('0, edg, 8'h00, 0, '0, 0, '0);
      repeat (3) drive('0, edg, 8'h10, 0, '0, 0, '0);
      drive('0, edg, 8'h10, 0, '0, 1, 8'h80);
      drive('0, edg, 8'h10, 0, '0, 1, 8'h80);
      repeat (3) drive('0, edg, 8'hFF, 0, '0, 0, '0);
      // All pending, then asynchronous reset
      drive('0, edg, 8'hFF, 0, '0, 1, 8'hFF);
      repeat (2) drive('0, edg, 8'hFF, 0, '0, 0, '0);
      async_reset();
      repeat (4) drive('0, edg, 8'hFF, 0, '0, 0, '0);

      // Random traffic; detect mode changes only occasionally
      edg = 8'($urandom);
      en  = 8'($urandom);
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 49) == 0) edg = 8'($urandom);
         if ($urandom_range(0, 9) == 0)  en  = 8'($urandom);
         if ($urandom_range(0, 299) == 0) async_reset();
         src = 8'($urandom & $urandom);
         drive(src, edg, en, ($urandom_range(0, 3) == 0), 8'($urandom),
               ($urandom_range(0, 7) == 0), 8'($urandom & $urandom));
      end
      drive('0, edg, en, 0, '0, 0, '0);
      repeat (3) @(negedge i_clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
